u409_cia_cycle: RTL and testbench
=================================

# u409_cia_cycle

CIA bus cycle responder for U409. It takes 68040 transfers that the address decoder has flagged as CIA space and runs them as E-clock-synchronous 8520 cycles. It generates the free-running E clock, drives the CIA_ENABLE qualifier that the decoder ANDs into CIACS0n/CIACS1n, controls data-buffer latch/drive, and terminates the CPU cycle with a one-clock TAn.

## Interface
Parameters:
- E_LOW, 34: CLK40 cycles E is low per period.
- E_HIGH, 22: CLK40 cycles E is high per period (period 56 cycles ≈ 714 kHz).
- SETUP_MIN, 6: minimum CLK40 cycles of CIA_ENABLE before E rises (used only with CIA_FAST_START_EN).

Ports:
- CLK40 in 1: 40 MHz CPU clock; all logic is on the rising edge.
- RESET in 1: synchronous reset, active-high.
- TSn in 1: 68040 transfer start, active-low, one clock wide.
- CIA_SPACE in 1: from the decoder; high when the address is in $00BF xxxx.
- RnW in 1: CPU read (1) or write (0); sampled with TSn.
- E out 1: CIA E clock.
- CIA_ENABLE out 1: CIA cycle active; the decoder gates chip selects with it.
- RD_LE out 1: one-clock read-data latch enable.
- WR_OEn out 1: active-low; drives CPU write data to the CIA bus.
- TAn out 1: active-low transfer acknowledge, one clock wide.

## Operation
- E counter `cnt`, 6 bits, 0..E_LOW+E_HIGH-1, wraps to 0. `E` is registered. It is low while cnt < E_LOW and high otherwise.
- The counter runs continuously and is independent of CPU activity.
- States:
  - IDLE: on TSn=0 and CIA_SPACE=1, latch RnW and go to WAIT. All other TSn are ignored.
  - WAIT: when cnt = PERIOD-1, go to ACTIVE.
  - ACTIVE: CIA_ENABLE=1. WR_OEn=0 if the latched cycle is a write. When cnt = PERIOD-2 and the cycle is a read, RD_LE=1 for the next cycle. When cnt = PERIOD-1, go to TERM.
  - TERM: TAn=0, CIA_ENABLE=0, WR_OEn=1. Next state is IDLE.
- All outputs are registered. The output value in a cycle reflects the state entered at that cycle's edge.
- TSn asserted while not in IDLE is ignored. The CPU does not overlap transfers.
- CIA_SPACE is sampled only in the cycle where TSn=0. Later changes have no effect.
- RESET (including mid-cycle), on the next edge:
  - cnt=0, E=0.
  - state IDLE.
  - CIA_ENABLE=0, RD_LE=0, WR_OEn=1, TAn=1.
  - No TAn is issued for an aborted cycle.

## Timing
- Request accepted at edge k with cnt=c.
  - WAIT lasts until the next wrap; ACTIVE begins in the cycle where cnt=0.
  - CIA_ENABLE is high for exactly PERIOD (56) cycles: one full E low and one full E high phase.
- RD_LE is high in the last E-high cycle (cnt=55), i.e. one cycle before E falls.
- TAn is low in the cycle where cnt=0 following ACTIVE. This coincides with E falling and CIA_ENABLE dropping.
- Latency from the TSn cycle to TAn low:
  - (PERIOD-1-c) + PERIOD + 1 cycles.
  - Minimum 57 (c=55), maximum 112 (c=0).
- Back-to-back: the next TSn is accepted in the cycle after TAn (state IDLE).

## Configuration
- Macro: `CIA_FAST_START_EN`.
- Defined: if the request is accepted with c ≤ E_LOW-SETUP_MIN-1 (c ≤ 27 at defaults), go directly to ACTIVE.
  - CIA_ENABLE rises at cnt=c+1, giving at least SETUP_MIN cycles before E rises.
  - The cycle finishes at the current period's wrap, so latency = PERIOD-c.
  - Requests with c > 27 behave as in the undefined case.
- Undefined: always wait for the next wrap, as described above.

## Test plan
- Reset, then run 112 clocks: E low for 34 and high for 22, repeating. CIA_ENABLE=0, TAn=1, WR_OEn=1 throughout.
- Read with TSn, CIA_SPACE=1, RnW=1 at cnt=10 (macro off):
  - CIA_ENABLE high for cnt 0..55 of the next period.
  - RD_LE is a single pulse at cnt=55.
  - TAn low one cycle, 102 clocks after TSn.
  - WR_OEn stays 1.
- Write at cnt=55: WR_OEn=0 exactly while CIA_ENABLE=1, TAn after 57 clocks, RD_LE never asserted.
- TSn with CIA_SPACE=0: no state change, no TAn. Then a second TSn, issued while a valid cycle is in ACTIVE, is ignored and produces exactly one TAn.
- Assert RESET at cnt=20 of ACTIVE:
  - Next edge: CIA_ENABLE=0, E=0, cnt=0.
  - No TAn within 200 clocks.
  - A new read then completes normally.
- With CIA_FAST_START_EN, read at cnt=10: CIA_ENABLE rises at cnt=11 and TAn arrives 46 clocks after TSn. A read at cnt=28 falls back to next-period timing (84 clocks).

Source files
------------

// File: rtl/u409_cia_cycle.sv
// CIA bus cycle responder: runs CPU transfers to CIA space as E-clock-synchronous 8520 cycles.
// Latency: TSn to TAn is (PERIOD-1-c)+PERIOD+1 clocks, or PERIOD-c with CIA_FAST_START_EN defined.
// Backpressure: none; one transfer at a time, TSn outside IDLE is ignored. Optional macro: CIA_FAST_START_EN.
module u409_cia_cycle #(
    parameter int E_LOW     = 34,
    parameter int E_HIGH    = 22,
    parameter int SETUP_MIN = 6
) (
    input  logic CLK40,
    input  logic RESET,
    input  logic TSn,
    input  logic CIA_SPACE,
    input  logic RnW,
    output logic E,
    output logic CIA_ENABLE,
    output logic RD_LE,
    output logic WR_OEn,
    output logic TAn
);

    localparam int          PERIOD   = E_LOW + E_HIGH;
    localparam logic [5:0]  CNT_LAST = 6'(PERIOD - 1);
    localparam logic [5:0]  CNT_PRE  = 6'(PERIOD - 2);
    // Latest counter value at which an immediate start still leaves SETUP_MIN clocks before E rises.
    localparam logic [5:0]  FAST_MAX = 6'(E_LOW - SETUP_MIN - 1);

`ifdef CIA_FAST_START_EN
    localparam logic FAST_EN = 1'b1;
`else
    localparam logic FAST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TERM   = 2'd3
    } state_t;

    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic       e_q;
    state_t     state_q;
    logic       rnw_q;
    logic       cia_enable_q;
    logic       rd_le_q;
    logic       wr_oen_q;
    logic       tan_q;
    logic       req_ok;
    logic       start_now;

    // Next value of the free-running E counter.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? 6'd0 : cnt_q + 6'd1;
    end

    // A request may go straight to ACTIVE when this edge is the period wrap,
    // or (fast start) when enough E-low time remains before E rises.
    always_comb begin
        req_ok    = !TSn && CIA_SPACE;
        start_now = (cnt_q == CNT_LAST) || (FAST_EN && (cnt_q <= FAST_MAX));
    end

    // E counter and registered E, aligned so E reflects the counter value of the same cycle.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            cnt_q <= 6'd0;
            e_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            e_q   <= (cnt_d >= 6'(E_LOW));
        end
    end

    // Cycle FSM with registered outputs that follow the state being entered.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            rnw_q        <= 1'b1;
            cia_enable_q <= 1'b0;
            rd_le_q      <= 1'b0;
            wr_oen_q     <= 1'b1;
            tan_q        <= 1'b1;
        end else begin
            rd_le_q <= 1'b0;
            tan_q   <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (req_ok) begin
                        rnw_q <= RnW;
                        if (start_now) begin
                            state_q      <= ST_ACTIVE;
                            cia_enable_q <= 1'b1;
                            wr_oen_q     <= RnW;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_ACTIVE;
                        cia_enable_q <= 1'b1;
                        wr_oen_q     <= rnw_q;
                    end
                end
                ST_ACTIVE: begin
                    // Latch read data in the last E-high clock, just before E falls.
                    if ((cnt_q == CNT_PRE) && rnw_q) begin
                        rd_le_q <= 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_TERM;
                        cia_enable_q <= 1'b0;
                        wr_oen_q     <= 1'b1;
                        tan_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign E          = e_q;
    assign CIA_ENABLE = cia_enable_q;
    assign RD_LE      = rd_le_q;
    assign WR_OEn     = wr_oen_q;
    assign TAn        = tan_q;

endmodule

// File: tb/tb_u409_cia_cycle.sv
// Directed bench for u409_cia_cycle: E waveform, read/write timing, ignored requests, reset abort.
// Expected windows are hand-computed per transaction and checked every clock.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_u409_cia_cycle;

    logic CLK40 = 1'b0;
    logic RESET = 1'b1;
    logic TSn = 1'b1;
    logic CIA_SPACE = 1'b0;
    logic RnW = 1'b1;
    logic E;
    logic CIA_ENABLE;
    logic RD_LE;
    logic WR_OEn;
    logic TAn;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int tcnt = 0;
    int tan_seen = 0;

    u409_cia_cycle dut (
        .CLK40(CLK40),
        .RESET(RESET),
        .TSn(TSn),
        .CIA_SPACE(CIA_SPACE),
        .RnW(RnW),
        .E(E),
        .CIA_ENABLE(CIA_ENABLE),
        .RD_LE(RD_LE),
        .WR_OEn(WR_OEn),
        .TAn(TAn)
    );

    always #5 CLK40 = ~CLK40;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (tcnt=%0d)", tag, obs, exp, tcnt);
        end
    endtask

    // Advance one clock; the bench's own E-period position follows.
    task automatic tick();
        @(posedge CLK40);
        #1;
        tcnt = (tcnt + 1) % 56;
    endtask

    task automatic chk_e();
        chk("E", {31'b0, E}, {31'b0, (tcnt >= 34)});
    endtask

    task automatic chk_idle(input string tag);
        chk_e();
        chk({tag, "_en"}, {31'b0, CIA_ENABLE}, 32'd0);
        chk({tag, "_ta"}, {31'b0, TAn}, 32'd1);
        chk({tag, "_oe"}, {31'b0, WR_OEn}, 32'd1);
        chk({tag, "_rd"}, {31'b0, RD_LE}, 32'd0);
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 56 && tcnt != c; i++) tick();
    endtask

    // Issue a transfer at counter value c and check every following clock.
    // n counts clocks after the TSn edge; CIA_ENABLE expected for en_first <= n < tan_at,
    // TAn low at n == tan_at. extra_ts_at issues an extra TSn; abort_at asserts RESET.
    task automatic do_cycle(input string tag, input logic rnw, input int c, input int en_first,
                            input int tan_at, input int ncyc, input int extra_ts_at,
                            input int abort_at);
        logic en_x;
        wait_cnt(c);
        chk({tag, "_start_cnt"}, 32'(tcnt), 32'(c));
        TSn = 1'b0; CIA_SPACE = 1'b1; RnW = rnw;
        tick();
        TSn = 1'b1; CIA_SPACE = 1'b0; RnW = 1'b1;
        tan_seen = 0;
        for (int n = 1; n <= ncyc; n++) begin
            en_x = (n >= en_first) && (n < tan_at);
            chk_e();
            chk({tag, "_en"}, {31'b0, CIA_ENABLE}, {31'b0, en_x});
            chk({tag, "_rd"}, {31'b0, RD_LE}, {31'b0, rnw && (n == tan_at - 1)});
            chk({tag, "_oe"}, {31'b0, WR_OEn}, {31'b0, !(en_x && !rnw)});
            chk({tag, "_ta"}, {31'b0, TAn}, {31'b0, (n != tan_at)});
            if (!TAn) tan_seen++;
            if (n == extra_ts_at) begin
                TSn = 1'b0; CIA_SPACE = 1'b1; RnW = 1'b1;
            end
            if (n == abort_at) begin
                RESET = 1'b1;
                tick();
                RESET = 1'b0;
                tcnt = 0;
                chk({tag, "_rst_en"}, {31'b0, CIA_ENABLE}, 32'd0);
                chk({tag, "_rst_e"}, {31'b0, E}, 32'd0);
                chk({tag, "_rst_ta"}, {31'b0, TAn}, 32'd1);
                return;
            end
            tick();
            TSn = 1'b1; CIA_SPACE = 1'b0;
        end
        chk({tag, "_ta_count"}, 32'(tan_seen), 32'd1);
    endtask

    initial begin
        // Reset and confirm idle outputs in the first cycle after it (cnt=0).
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        tcnt = 0;
        chk_idle("reset");

        // Two full E periods with no activity.
        for (int i = 0; i < 112; i++) begin
            tick();
            chk_idle("idle");
        end

`ifndef CIA_FAST_START_EN
        // Read at cnt=10: ACTIVE 46..101, RD_LE at 101, TAn at 102.
        do_cycle("rd10", 1'b1, 10, 46, 102, 110, -1, -1);
`else
        // Fast start read at cnt=10: ACTIVE from cnt=11, TAn at 46.
        do_cycle("frd10", 1'b1, 10, 1, 46, 60, -1, -1);
`endif
        // Read at cnt=28 is past the fast-start window in either build: TAn at 84.
        do_cycle("rd28", 1'b1, 28, 28, 84, 90, -1, -1);

        // Write at cnt=55: ACTIVE immediately for 56 clocks, TAn at 57.
        do_cycle("wr55", 1'b0, 55, 1, 57, 62, -1, -1);

        // TSn with CIA_SPACE=0 is ignored.
        wait_cnt(3);
        TSn = 1'b0; CIA_SPACE = 1'b0; RnW = 1'b1;
        tick();
        TSn = 1'b1;
        for (int i = 0; i < 120; i++) begin
            chk_idle("nospace");
            tick();
        end

        // Read at cnt=0 (longest latency, 112) with a stray TSn during ACTIVE.
`ifndef CIA_FAST_START_EN
        do_cycle("rd0", 1'b1, 0, 56, 112, 118, 70, -1);
`else
        do_cycle("frd0", 1'b1, 0, 1, 56, 118, 30, -1);
`endif

        // Reset at cnt=20 of ACTIVE for a read accepted at cnt=5.
`ifndef CIA_FAST_START_EN
        do_cycle("abort", 1'b1, 5, 51, 107, 120, -1, 71);
`else
        do_cycle("abort", 1'b1, 5, 1, 51, 120, -1, 15);
`endif
        for (int i = 0; i < 200; i++) begin
            tick();
            chk_idle("post_rst");
        end

        // A new read completes normally after the abort.
`ifndef CIA_FAST_START_EN
        do_cycle("rd_after", 1'b1, 10, 46, 102, 110, -1, -1);
`else
        do_cycle("rd_after", 1'b1, 10, 1, 46, 60, -1, -1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
